fft8_unloader: RTL and testbench

//  Output-side consumer of the 8-point combine stage. Captures its 8 parallel complex results
//  (fixed-latency, no valid) and streams them one complex word per cycle over valid/ready.
//  Two-bank buffer: a new frame may land while the previous one drains.

---
 rtl/fft8_unloader_if.sv | 24 ++
 rtl/fft8_unloader.sv | 136 +++++++++++++
 tb/tb_fft8_unloader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_unloader_if.sv
// fft8_unloader_if
//   Result stream carried out of the 8-point FFT unloader: one complex word per
//   cycle with a valid/ready handshake.
//   Signals:
//     valid  word on re/im/idx/last is valid
//     ready  consumer accepts the word this cycle
//     re     real part of the word
//     im     imaginary part of the word
//     idx    FFT bin index of the word
//     last   marks the eighth word of a frame
//   Modports: master (unloader side), slave (consumer side).
interface fft8_unloader_if #(
  parameter int DW = 32
);
  logic                 valid;
  logic                 ready;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic [2:0]           idx;
  logic                 last;

  modport master (output valid, re, im, idx, last, input ready);
  modport slave  (input valid, re, im, idx, last, output ready);
endinterface

// File: rtl/fft8_unloader.sv
// fft8_unloader
//   Output-side consumer of the 8-point combine stage. The combine stage has a
//   fixed latency and no valid strobe, so the frame start pulse is delayed LAT
//   cycles to find the cycle its eight complex results are present. Results
//   land in one of two banks and are streamed one complex word per cycle; a new
//   frame can be captured while the previous one drains.
//   Ports:
//     clk      clock, rising edge
//     rst      asynchronous active-high reset (deassertion re-timed internally)
//     start    frame inputs presented to the combine stage this cycle
//     in_real  combine outputs, word k at [k*DW +: DW]
//     in_imag  same layout, imaginary parts
//     out      result stream (fft8_unloader_if.master)
//     busy     a bank holds a frame or a capture is still in the delay line
//     drop     one-cycle pulse: a frame was lost because no bank was free
//     err      sticky drop flag, cleared only by reset
//   Build option: define FFT8_UNLOAD_BITREV_EN to emit bins in bit-reversed
//   order (0,4,2,6,1,5,3,7); otherwise natural order.
module fft8_unloader #(
  parameter int DW  = 32,
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*DW-1:0]     in_real,
  input  logic [8*DW-1:0]     in_imag,
  fft8_unloader_if.master     out,
  output logic                busy,
  output logic                drop,
  output logic                err
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [1:0]           rst_pipe;
  logic                 rst_hold;
  logic [LAT-1:0]       dly;
  logic [1:0]           full, full_nxt;
  logic                 wr_ptr, wr_nxt;
  logic                 rd_ptr, rd_nxt;
  logic [2:0]           cnt, cnt_nxt;
  logic                 cap, hs, rel, cap_ok, drop_nxt;
  logic [2:0]           sel;
  logic signed [DW-1:0] bank_re [2][8];
  logic signed [DW-1:0] bank_im [2][8];

`ifdef FFT8_UNLOAD_BITREV_EN
  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction
  assign sel = bitrev3(cnt);
`else
  assign sel = cnt;
`endif

  // Reset release is held for two extra clocks so deassertion is synchronous
  // to clk even though assertion takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_hold = rst_pipe[1];

  // Next-state / bank bookkeeping.
  always_comb begin
    cap      = dly[LAT-1];
    hs       = (state == STREAM) && out.ready;
    rel      = hs && (cnt == 3'd7);
    // A bank released by the last handshake this cycle may be rewritten at once.
    cap_ok   = cap && (!full[wr_ptr] || (rel && (rd_ptr == wr_ptr)));
    drop_nxt = cap && !cap_ok;
    full_nxt = full;
    if (rel)    full_nxt[rd_ptr] = 1'b0;
    if (cap_ok) full_nxt[wr_ptr] = 1'b1;
    wr_nxt    = cap_ok ? ~wr_ptr : wr_ptr;
    rd_nxt    = rel ? ~rd_ptr : rd_ptr;
    cnt_nxt   = hs ? cnt + 3'd1 : cnt;
    // Looking at the next fill state lets a frame captured in the same cycle
    // as a last handshake follow on with no bubble, and starts streaming the
    // cycle right after a capture when idle.
    state_nxt = full_nxt[rd_nxt] ? STREAM : IDLE;
  end

  // Control registers: delay line, flags, pointers, counter, FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dly    <= '0;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      drop   <= 1'b0;
      err    <= 1'b0;
    end else if (rst_hold) begin
      state  <= IDLE;
      dly    <= '0;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      drop   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      dly    <= (dly << 1) | LAT'(start);
      full   <= full_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      drop   <= drop_nxt;
      err    <= err | drop_nxt;
    end
  end

  // Bank storage: written only on an accepted capture, never reset.
  always_ff @(posedge clk) begin
    if (cap_ok) begin
      for (int k = 0; k < 8; k++) begin
        bank_re[wr_ptr][k] <= $signed(in_real[k*DW +: DW]);
        bank_im[wr_ptr][k] <= $signed(in_imag[k*DW +: DW]);
      end
    end
  end

  // Output word: selected from registered state only, forced to zero when idle.
  assign out.valid = (state == STREAM);
  assign out.re    = out.valid ? bank_re[rd_ptr][sel] : '0;
  assign out.im    = out.valid ? bank_im[rd_ptr][sel] : '0;
  assign out.idx   = out.valid ? sel : 3'd0;
  assign out.last  = out.valid && (cnt == 3'd7);
  assign busy      = (|full) | (|dly);

endmodule

// File: tb/tb_fft8_unloader.sv
// tb_fft8_unloader
//   Directed bench for fft8_unloader (DW=32, LAT=3). Frame data for base b:
//   bin k real = b+k+1, imag = -(b+k+1). Follows FFT8_UNLOAD_BITREV_EN for
//   the expected bin order.
module tb_fft8_unloader;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int WW  = 2*DW + 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [8*DW-1:0] in_real;
  logic [8*DW-1:0] in_imag;
  logic            busy, drop, err;
  logic [WW-1:0]   obs;

  int checks = 0;
  int errors = 0;

  fft8_unloader_if #(.DW(DW)) bus ();

  fft8_unloader #(.DW(DW), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_real (in_real),
    .in_imag (in_imag),
    .out     (bus.master),
    .busy    (busy),
    .drop    (drop),
    .err     (err)
  );

  always #5 clk = ~clk;

  assign obs = {bus.valid, bus.re, bus.im, bus.idx, bus.last};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int base);
    for (int k = 0; k < 8; k++) begin
      in_real[k*DW +: DW] = DW'(base + k + 1);
      in_imag[k*DW +: DW] = DW'(-(base + k + 1));
    end
  endtask

  function automatic logic [2:0] exp_bin(input int c);
`ifdef FFT8_UNLOAD_BITREV_EN
    int order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    return 3'(order[c]);
`else
    return 3'(c);
`endif
  endfunction

  function automatic logic [WW-1:0] exp_word(input int base, input int c);
    logic [2:0] b;
    int v;
    b = exp_bin(c);
    v = base + int'(b) + 1;
    return {1'b1, DW'(v), DW'(-v), b, (c == 7)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.ready = 1'b0;
    in_real = '0; in_imag = '0;
    repeat (3) tick();
    checks++;
    if ({obs, busy, drop, err} !== '0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", {obs, busy, drop, err});
    end
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({obs, busy, drop, err} !== '0) begin
      errors++; $display("FAIL reset_release: got %h expected 0", {obs, busy, drop, err});
    end
  endtask

  task automatic test_single_frame();
    set_frame(0);
    bus.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      checks++;
      if (bus.valid !== 1'b0) begin
        errors++; $display("FAIL single_latency cyc%0d: valid=%b expected 0", i, bus.valid);
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (obs !== exp_word(0, c)) begin
        errors++; $display("FAIL single_word%0d: got %h expected %h", c, obs, exp_word(0, c));
      end
      tick();
    end
    checks++;
    if ({bus.valid, busy, drop, err} !== 4'b0000) begin
      errors++; $display("FAIL single_end: valid/busy/drop/err=%b expected 0000",
                         {bus.valid, busy, drop, err});
    end
  endtask

  task automatic test_backpressure();
    int w;
    set_frame(1000);
    bus.ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && bus.valid !== 1'b1; n++) tick();
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++; $display("FAIL bp_timeout: valid=%b expected 1", bus.valid);
    end
    w = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.ready = (cyc % 2 == 1);
      checks++;
      if (obs !== exp_word(1000, w)) begin
        errors++; $display("FAIL bp_cyc%0d: got %h expected %h", cyc, obs, exp_word(1000, w));
      end
      tick();
      if (bus.ready) w++;
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++; $display("FAIL bp_end: valid=%b expected 0", bus.valid);
    end
    bus.ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    bus.ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          set_frame(100 * (f + 1));
          start = 1'b1;
          tick();
          start = 1'b0;
          repeat (7) tick();
        end
      end
      begin
        for (int n = 0; n < 20 && bus.valid !== 1'b1; n++) tick();
        for (int w = 0; w < 32; w++) begin
          checks++;
          if (obs !== exp_word(100 * (w / 8 + 1), w % 8)) begin
            errors++; $display("FAIL b2b_word%0d: got %h expected %h", w, obs,
                               exp_word(100 * (w / 8 + 1), w % 8));
          end
          tick();
        end
        checks++;
        if ({bus.valid, drop, err} !== 3'b000) begin
          errors++; $display("FAIL b2b_end: valid/drop/err=%b expected 000", {bus.valid, drop, err});
        end
      end
    join
  endtask

  task automatic test_overflow();
    bus.ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      set_frame(2000 + 1000 * f);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < ((f < 2) ? 4 : 3); i++) begin
        checks++;
        if (drop !== 1'b0) begin
          errors++; $display("FAIL ovf_nodrop f%0d c%0d: drop=%b expected 0", f, i, drop);
        end
        tick();
      end
    end
    checks++;
    if ({drop, err, busy} !== 3'b111) begin
      errors++; $display("FAIL ovf_drop_pulse: drop/err/busy=%b expected 111", {drop, err, busy});
    end
    tick();
    checks++;
    if ({drop, err} !== 2'b01) begin
      errors++; $display("FAIL ovf_after_pulse: drop/err=%b expected 01", {drop, err});
    end
    checks++;
    if (obs !== exp_word(2000, 0)) begin
      errors++; $display("FAIL ovf_stall_word: got %h expected %h", obs, exp_word(2000, 0));
    end
    bus.ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (obs !== exp_word(2000 + 1000 * (w / 8), w % 8)) begin
        errors++; $display("FAIL ovf_word%0d: got %h expected %h", w, obs,
                           exp_word(2000 + 1000 * (w / 8), w % 8));
      end
      tick();
    end
    checks++;
    if ({bus.valid, err} !== 2'b01) begin
      errors++; $display("FAIL ovf_end: valid/err=%b expected 01", {bus.valid, err});
    end
  endtask

  task automatic test_rst_mid();
    set_frame(6000);
    bus.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && bus.valid !== 1'b1; n++) tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (obs !== exp_word(6000, 3)) begin
      errors++; $display("FAIL rst_mid_word3: got %h expected %h", obs, exp_word(6000, 3));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({obs, busy, drop, err} !== '0) begin
      errors++; $display("FAIL rst_mid_async: got %h expected 0", {obs, busy, drop, err});
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({bus.valid, busy, drop} !== 3'b000) begin
        errors++; $display("FAIL rst_mid_quiet c%0d: valid/busy/drop=%b expected 000",
                           i, {bus.valid, busy, drop});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
